// File: rtl/button_event_ctrl_pkg.sv
// Shared types and helpers for the push-button event controller.
package button_event_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  localparam int unsigned MAX_BTN  = 8;
  localparam int unsigned MAX_ID_W = 3;

  // Round-robin pick: first set bit of req scanning ptr, ptr+1, ... mod n.
  // Returns {found, index}.
  function automatic logic [MAX_ID_W:0] rr_pick(input logic [MAX_BTN-1:0]  req,
                                                input logic [MAX_ID_W-1:0] ptr,
                                                input int unsigned         n);
    logic [MAX_ID_W:0] res;
    int unsigned       idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_BTN; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !res[MAX_ID_W] && req[MAX_ID_W'(idx)]) begin
        res = {1'b1, MAX_ID_W'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/button_event_ctrl_filter.sv
// Per-button synchroniser, sample shift register with hysteresis, and press pulse.
module button_event_ctrl_filter #(
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [1:0]            sync;
  logic [STABLE_CNT-1:0] samples;
  logic [STABLE_CNT-1:0] samples_nxt;

  assign samples_nxt = {samples[STABLE_CNT-2:0], sync[1]};

  // Level only moves when the whole sample window agrees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      samples <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (tick) begin
        samples <= samples_nxt;
        if (&samples_nxt) begin
          level <= 1'b1;
          rise  <= ~level;
        end else if (~|samples_nxt) begin
          level <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Button front end: shared sample prescaler, per-button filters, pending
// presses and a round-robin arbiter feeding a valid/ready event port.
module button_event_ctrl
  import button_event_ctrl_pkg::*;
#(
  parameter int unsigned N_BTN      = 5,
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic [N_BTN-1:0]         pending,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic                     overrun
);

  localparam int unsigned ID_W  = $clog2(N_BTN);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic [N_BTN-1:0]  rise;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_ptr_nxt;
  logic [N_BTN-1:0]  clr;
  logic [N_BTN-1:0]  pending_nxt;
  logic              overrun_nxt;
  logic              accept;
  logic [MAX_ID_W:0] pick_idle;
  logic [MAX_ID_W:0] pick_b2b;
  logic              evt_valid_nxt;
  logic [ID_W-1:0]   evt_id_nxt;
  state_t            state;
  state_t            state_nxt;

  // Shared sample-tick prescaler.
  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_filt
    button_event_ctrl_filter #(
      .STABLE_CNT(STABLE_CNT)
    ) u_filt (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (rise[i])
    );
  end

  // Pending bookkeeping: a new press beats a same-cycle clear.
  assign accept      = (state == ST_OFFER) && evt_ready;
  assign clr         = accept ? (N_BTN'(1) << evt_id) : '0;
  assign pending_nxt = (pending & ~clr) | rise;
  assign overrun_nxt = |(rise & pending & ~clr);
  assign rr_ptr_nxt  = !accept ? rr_ptr :
                       (evt_id == ID_W'(N_BTN - 1)) ? '0 : evt_id + ID_W'(1);

  assign pick_idle = rr_pick(MAX_BTN'(pending), MAX_ID_W'(rr_ptr), N_BTN);
  assign pick_b2b  = rr_pick(MAX_BTN'(pending_nxt), MAX_ID_W'(rr_ptr_nxt), N_BTN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_idle[MAX_ID_W]) state_nxt = ST_OFFER;
      ST_OFFER: if (evt_ready && !pick_b2b[MAX_ID_W]) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Offer the next grant in the same cycle as an accept when one remains.
  always_comb begin
    evt_valid_nxt = evt_valid;
    evt_id_nxt    = evt_id;
    case (state)
      ST_IDLE: begin
        if (pick_idle[MAX_ID_W]) begin
          evt_valid_nxt = 1'b1;
          evt_id_nxt    = ID_W'(pick_idle[MAX_ID_W-1:0]);
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          if (pick_b2b[MAX_ID_W]) begin
            evt_valid_nxt = 1'b1;
            evt_id_nxt    = ID_W'(pick_b2b[MAX_ID_W-1:0]);
          end else begin
            evt_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        evt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      overrun   <= 1'b0;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      pending   <= pending_nxt;
      overrun   <= overrun_nxt;
      rr_ptr    <= rr_ptr_nxt;
      evt_valid <= evt_valid_nxt;
      evt_id    <= evt_id_nxt;
    end
  end

endmodule
